// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the memory-mapped UART receiver.
// Register word offsets are decoded on addr[4:2].
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        COMMIT
    } rx_state_e;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_DIV    = 3'd3;

    localparam int CTRL_RX_EN    = 0;
    localparam int CTRL_TWO_STOP = 1;
    localparam int CTRL_ODD_PAR  = 2;
    localparam int CTRL_IRQ_EN   = 3;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_PAR_ERR = 2;
    localparam int STAT_FRM_ERR = 3;
    localparam int STAT_OVERRUN = 4;
    localparam int STAT_CNT_LSB = 5;

    localparam int MIN_DIV = 4;

    // Parity bit a correct transmitter would send for this byte.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with first-word-fall-through head; a pop frees space for a
// same-cycle push even when full, and pops on empty are ignored.
module rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data_in,
    output logic [W-1:0]               o_data_out,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty    = (r_count == (AW+1)'(0));
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_count    = r_count;
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign o_data_out = o_empty ? W'(0) : r_mem[r_rd_ptr];

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= (AW+1)'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises Rx_in, deframes 8E/8O with 1 or 2 stop bits,
// and queues bytes in a FIFO popped by DATA register reads.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        Rx_in,
    output logic [31:0] rdata,
    output logic        rx_irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_e        r_state;
    rx_state_e        w_state_nxt;
    logic [3:0]       r_ctrl;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [DIV_W-1:0] w_baud_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_d;
    logic             r_parity_err;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_irq;
    logic             w_set_perr;
    logic             w_set_ferr;
    logic             w_commit;
    logic             w_enable;
    logic             w_fall;
    logic             w_half_hit;
    logic             w_bit_hit;
    logic             w_pop;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_wr_div;
    logic [7:0]       w_fifo_head;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [31:0]      w_status;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_enable    = r_ctrl[CTRL_RX_EN] & (r_div >= DIV_W'(MIN_DIV));
    assign w_fall      = r_sync_d & ~r_sync2;
    assign w_half_hit  = (r_baud_cnt == ((r_div >> 1) - DIV_W'(1)));
    assign w_bit_hit   = (r_baud_cnt == (r_div - DIV_W'(1)));
    assign w_pop       = rd_en & (addr[4:2] == REG_DATA);
    assign w_wr_ctrl   = wr_en & (addr[4:2] == REG_CTRL);
    assign w_wr_status = wr_en & (addr[4:2] == REG_STATUS);
    assign w_wr_div    = wr_en & (addr[4:2] == REG_DIV);
    assign w_unused    = ^{addr[31:5], addr[1:0], wdata[31:DIV_W]};

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= Rx_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Receive FSM and bit-timing state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= DIV_W'(0);
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Next-state logic; disabling the receiver forces IDLE with no side effects.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + DIV_W'(1);
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_set_perr  = 1'b0;
        w_set_ferr  = 1'b0;
        w_commit    = 1'b0;
        if (!w_enable) begin
            w_state_nxt = IDLE;
            w_baud_nxt  = DIV_W'(0);
        end else begin
            case (r_state)
                IDLE: begin
                    w_baud_nxt = DIV_W'(0);
                    if (w_fall) begin
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                START: begin
                    if (w_half_hit) begin
                        w_baud_nxt  = DIV_W'(0);
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = r_sync2 ? IDLE : DATA;
                    end else begin
                        w_state_nxt = START;
                    end
                end
                DATA: begin
                    if (w_bit_hit) begin
                        w_baud_nxt  = DIV_W'(0);
                        w_shift_nxt = {r_sync2, r_shift[7:1]};
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                        w_state_nxt = (r_bit_cnt == 3'd7) ? PARITY : DATA;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
                PARITY: begin
                    if (w_bit_hit) begin
                        w_baud_nxt  = DIV_W'(0);
                        w_set_perr  = (r_sync2 != parity_bit(r_shift, r_ctrl[CTRL_ODD_PAR]));
                        w_state_nxt = STOP1;
                    end else begin
                        w_state_nxt = PARITY;
                    end
                end
                STOP1: begin
                    if (w_bit_hit) begin
                        w_baud_nxt  = DIV_W'(0);
                        w_set_ferr  = ~r_sync2;
                        w_state_nxt = r_ctrl[CTRL_TWO_STOP] ? STOP2 : COMMIT;
                    end else begin
                        w_state_nxt = STOP1;
                    end
                end
                STOP2: begin
                    if (w_bit_hit) begin
                        w_baud_nxt  = DIV_W'(0);
                        w_set_ferr  = ~r_sync2;
                        w_state_nxt = COMMIT;
                    end else begin
                        w_state_nxt = STOP2;
                    end
                end
                COMMIT: begin
                    w_baud_nxt  = DIV_W'(0);
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_baud_nxt  = DIV_W'(0);
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_commit),
        .i_pop      (w_pop),
        .i_data_in  (r_shift),
        .o_data_out (w_fifo_head),
        .o_count    (w_fifo_count),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full)
    );

    // Control registers, sticky error flags (set wins over W1C) and interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl       <= 4'h0;
            r_div        <= DIV_W'(0);
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= wdata[3:0];
            end
            if (w_wr_div) begin
                r_div <= wdata[DIV_W-1:0];
            end
            r_parity_err <= w_set_perr |
                            (r_parity_err & ~(w_wr_status & wdata[STAT_PAR_ERR]));
            r_frame_err  <= w_set_ferr |
                            (r_frame_err & ~(w_wr_status & wdata[STAT_FRM_ERR]));
            r_overrun    <= (w_commit & w_fifo_full & ~w_pop) |
                            (r_overrun & ~(w_wr_status & wdata[STAT_OVERRUN]));
            r_irq        <= r_ctrl[CTRL_IRQ_EN] & ~w_fifo_empty;
        end
    end

    // Status word assembly.
    always_comb begin
        w_status                           = 32'h0000_0000;
        w_status[STAT_EMPTY]               = w_fifo_empty;
        w_status[STAT_FULL]                = w_fifo_full;
        w_status[STAT_PAR_ERR]             = r_parity_err;
        w_status[STAT_FRM_ERR]             = r_frame_err;
        w_status[STAT_OVERRUN]             = r_overrun;
        w_status[STAT_CNT_LSB +: CNT_W]    = w_fifo_count;
    end

    // Combinational read mux, zero when not reading.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (rd_en) begin
            case (addr[4:2])
                REG_DATA:   w_rdata = {24'h00_0000, w_fifo_head};
                REG_CTRL:   w_rdata = {28'h000_0000, r_ctrl};
                REG_STATUS: w_rdata = w_status;
                REG_DIV:    w_rdata = {{(32-DIV_W){1'b0}}, r_div};
                default:    w_rdata = 32'h0000_0000;
            endcase
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    assign rdata  = w_rdata;
    assign rx_irq = r_irq;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven at 16 clocks per bit and
// results checked against hand-computed register values.
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        Rx_in = 1'b1;
    logic [31:0] rdata;
    logic        rx_irq;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] d;

    localparam logic [31:0] A_DATA = 32'h0, A_CTRL = 32'h4, A_STAT = 32'h8, A_DIV = 32'hC;

    uart_rx dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .Rx_in  (Rx_in),
        .rdata  (rdata),
        .rx_irq (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        @(posedge clk); #1 addr = a; wdata = v; wr_en = 1'b1;
        @(posedge clk); #1 wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        @(posedge clk); #1 addr = a; rd_en = 1'b1;
        #1 v = rdata;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    // Start, 8 data LSB first, parity, stop(s), then idle; 16 clocks per bit.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic s1,
                              input logic s2, input logic two);
        @(posedge clk); #1 Rx_in = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 Rx_in = b[i];
            repeat (16) @(posedge clk);
        end
        #1 Rx_in = par;
        repeat (16) @(posedge clk);
        #1 Rx_in = s1;
        repeat (16) @(posedge clk);
        if (two) begin
            #1 Rx_in = s2;
            repeat (16) @(posedge clk);
        end
        #1 Rx_in = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset();
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL reset_status got %h want %h", d, 32'h1); end
        rd(A_CTRL, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want %h", d, 32'h0); end
        rd(A_DIV, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_div got %h want %h", d, 32'h0); end
        n_cmp++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", rx_irq); end
        rd(32'h10, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h want %h", d, 32'h0); end
        @(posedge clk); #1 addr = A_STAT;
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_idle got %h want %h", rdata, 32'h0); end
    endtask

    task automatic test_basic();
        wr(A_DIV, 32'd16);
        wr(A_CTRL, 32'h1);
        rd(A_DIV, d);
        n_cmp++; if (d !== 32'd16) begin n_fail++; $display("FAIL div_rw got %h want %h", d, 32'd16); end
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h20) begin n_fail++; $display("FAIL basic_status got %h want %h", d, 32'h20); end
        n_cmp++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled got %b want 0", rx_irq); end
        wr(A_CTRL, 32'h9);
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (rx_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b want 1", rx_irq); end
        rd(A_DATA, d);
        n_cmp++; if (d !== 32'hA5) begin n_fail++; $display("FAIL basic_data got %h want %h", d, 32'hA5); end
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", rx_irq); end
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL basic_empty got %h want %h", d, 32'h1); end
        rd(A_DATA, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL empty_data got %h want %h", d, 32'h0); end
        wr(A_CTRL, 32'h1);
    endtask

    task automatic test_glitch();
        @(posedge clk); #1 Rx_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 Rx_in = 1'b1;
        repeat (40) @(posedge clk);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL glitch_status got %h want %h", d, 32'h1); end
    endtask

    task automatic test_parity();
        wr(A_CTRL, 32'h5);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h24) begin n_fail++; $display("FAIL parity_status got %h want %h", d, 32'h24); end
        wr(A_STAT, 32'h4);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h20) begin n_fail++; $display("FAIL parity_w1c got %h want %h", d, 32'h20); end
        rd(A_DATA, d);
        n_cmp++; if (d !== 32'hA5) begin n_fail++; $display("FAIL parity_data got %h want %h", d, 32'hA5); end
    endtask

    task automatic test_frame();
        wr(A_CTRL, 32'h3);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h48) begin n_fail++; $display("FAIL frame_status got %h want %h", d, 32'h48); end
        rd(A_DATA, d);
        n_cmp++; if (d !== 32'h3C) begin n_fail++; $display("FAIL frame_data0 got %h want %h", d, 32'h3C); end
        rd(A_DATA, d);
        n_cmp++; if (d !== 32'h5A) begin n_fail++; $display("FAIL frame_data1 got %h want %h", d, 32'h5A); end
        wr(A_STAT, 32'h8);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL frame_w1c got %h want %h", d, 32'h1); end
        wr(A_CTRL, 32'h1);
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        for (int i = 1; i <= 9; i++) begin
            b = 8'(i);
            send_frame(b, ^b, 1'b1, 1'b1, 1'b0);
        end
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h112) begin n_fail++; $display("FAIL ovr_status got %h want %h", d, 32'h112); end
        for (int i = 1; i <= 8; i++) begin
            rd(A_DATA, d);
            n_cmp++; if (d !== 32'(i)) begin n_fail++; $display("FAIL ovr_data%0d got %h want %h", i, d, 32'(i)); end
        end
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h11) begin n_fail++; $display("FAIL ovr_sticky got %h want %h", d, 32'h11); end
        wr(A_STAT, 32'h10);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            send_frame(b, ^b, 1'b1, 1'b1, 1'b0);
        end
        // The COMMIT cycle of a frame starting after edge 0 lies between edges 171 and 172.
        fork
            send_frame(8'h09, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (171) @(posedge clk);
                #1 addr = A_DATA; rd_en = 1'b1;
                #1;
                n_cmp++; if (rdata !== 32'h01) begin n_fail++; $display("FAIL b2b_pop got %h want %h", rdata, 32'h01); end
                @(posedge clk); #1 rd_en = 1'b0;
            end
        join
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h102) begin n_fail++; $display("FAIL b2b_status got %h want %h", d, 32'h102); end
        for (int i = 2; i <= 9; i++) begin
            rd(A_DATA, d);
            n_cmp++; if (d !== 32'(i)) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", i, d, 32'(i)); end
        end
    endtask

    task automatic test_midframe_reset();
        fork
            send_frame(8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (60) @(posedge clk);
                #1 reset = 1'b0;
                repeat (3) @(posedge clk);
                #1 reset = 1'b1;
            end
        join
        rd(A_CTRL, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl got %h want %h", d, 32'h0); end
        rd(A_DIV, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_div got %h want %h", d, 32'h0); end
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL rst_status got %h want %h", d, 32'h1); end
        wr(A_DIV, 32'd16);
        wr(A_CTRL, 32'h1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h20) begin n_fail++; $display("FAIL rst_rx_status got %h want %h", d, 32'h20); end
        rd(A_DATA, d);
        n_cmp++; if (d !== 32'h3C) begin n_fail++; $display("FAIL rst_rx_data got %h want %h", d, 32'h3C); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame();
        test_overrun();
        test_back_to_back();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Memory-mapped UART receiver; the receive-side counterpart of the team's UART transmitter on the same pipeline data bus. Frame format matches the transmitter: 1 start bit, 8 data bits LSB first, 1 parity bit (even/odd), 1 or 2 stop bits, with one bit every `divisor` clocks. It synchronises and samples the serial line and pushes received bytes into an 8-deep FIFO that the core pops through register reads. Sticky error flags and an optional interrupt are exposed to the core.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries (power of 2)
DIV_W, 14, baud divisor width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (low = reset asserted)
addr  in  32  byte address of register access
wdata  in  32  write data
wr_en  in  1  register write strobe
rd_en  in  1  register read strobe
Rx_in  in  1  serial line, idle high, asynchronous to clk
rdata  out  32  read data (combinational)
rx_irq  out  1  interrupt request

Behaviour:
- Register map, decoded on addr[4:2]:
  - 0x00 DATA: read returns {24'b0, FIFO head} and pops one entry if non-empty; reads 0 when empty; writes ignored.
  - 0x04 CTRL (RW): [0] rx_en, [1] two_stop, [2] odd_parity, [3] irq_en.
  - 0x08 STATUS: [0] empty, [1] full, [2] parity_err, [3] frame_err, [4] overrun, [8:5] fifo count. Bits [4:2] are sticky and write-1-to-clear.
  - 0x0C DIV (RW): [DIV_W-1:0] divisor.
- rdata equals the selected register when rd_en=1, otherwise 0. Unmapped addresses read 0.
- Reset (asynchronous): CTRL=0, DIV=0, FIFO empty, sticky flags=0, state IDLE, synchroniser flops=1, rx_irq=0.
- Rx_in passes through a 2-flop synchroniser (2-cycle latency). Falling-edge detect uses the synchronised value and its 1-cycle delay.
- Receiver is enabled only when rx_en=1 and DIV>=4. Otherwise the FSM is held in IDLE.
- FSM states and transitions:
  - IDLE: on a falling edge, clear baud_cnt and go to START.
  - START: when baud_cnt==(DIV>>1)-1, sample the line. Low → DATA with baud_cnt=0, bit_cnt=0. High → IDLE (glitch rejected).
  - DATA: when baud_cnt==DIV-1, sample, shift into the shift register MSB (LSB-first assembly), bit_cnt++, baud_cnt=0. After 8 bits → PARITY.
  - PARITY: at baud_cnt==DIV-1, compute expected parity = ^data (even) or ~^data (odd). A mismatch sets parity_err. Go to STOP1.
  - STOP1: at baud_cnt==DIV-1, a low sample sets frame_err. If two_stop → STOP2, else COMMIT.
  - STOP2: same check as STOP1, then COMMIT.
  - COMMIT: single cycle. Push byte if not full; if full, set overrun and drop the byte. Then → IDLE.
- Bytes with parity or frame errors are still pushed; errors are reported only through the sticky flags.
- After a break (stop bit sampled low), the line must return high before IDLE accepts a new falling edge.
- Clearing rx_en mid-frame aborts to IDLE on the next cycle; no push occurs and no flags are set. Writes to DIV or CTRL format bits mid-frame take effect immediately; software changes them only when idle.
- FIFO boundary rules:
  - Push and pop in the same cycle: both are performed and the count is unchanged.
  - When full, a same-cycle pop frees space, so no overrun is raised.
  - Pop when empty: no-op.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- rx_irq = irq_en & ~empty, registered (1-cycle latency).
- Latency from the mid-sample of the last stop bit to the byte being visible in the FIFO: 2 cycles.

Decomposition:
- Package uart_rx_pkg contains:
  - rx_state_e enum: IDLE, START, DATA, PARITY, STOP1, STOP2, COMMIT.
  - Register offset constants: DATA, CTRL, STATUS, DIV.
  - STATUS and CTRL bit-index constants.
  - MIN_DIV=4.
- One sub-module, rx_fifo: synchronous FIFO with push, pop, data_in, data_out, count, empty and full; first-word-fall-through head.

Test Plan:
- DIV=16, CTRL=0x1; drive 0xA5 (bits 1,0,1,0,0,1,0,1), parity 0, stop 1 → STATUS count=1 with no errors; DATA read returns 0x000000A5; then empty=1.
- DIV=16, rx_en=1; 5-cycle low pulse on Rx_in → FSM returns to IDLE; FIFO remains empty; no flags set.
- CTRL=0x5 (odd parity); send 0xA5 with parity 0 → parity_err=1 and byte is pushed; write 0x04 to STATUS → parity_err=0.
- CTRL=0x3 (two_stop); second stop bit low → frame_err=1 and byte is pushed; the next frame after the line returns high is received correctly.
- Send 9 bytes 0x01..0x09 with no reads → full=1, overrun=1; reads return 0x01..0x08 in order. Repeat with a DATA read coincident with the 9th COMMIT → no overrun, and 0x09 is stored.
- Assert reset mid-DATA, release it, then send 0x3C → all registers are at reset values; after reprogramming CTRL and DIV, 0x3C is received with no errors.
